// File: rtl/zet_ng_wb_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : zet_ng_wb_sram_bridge
// Description : Wishbone B3 slave to single-port synchronous SRAM bridge.
//               Handles classic cycles and incrementing / wrapping bursts.
//               The SRAM has a 1-cycle read latency, so reads are issued one
//               beat ahead; bursts then run at one beat per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module zet_ng_wb_sram_bridge #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [2:0]              wb_cti_i,
    input  logic [1:0]              wb_bte_i,
    output logic                    wb_ack_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-3:0]   ram_addr_o,
    output logic [DATA_WIDTH/8-1:0] ram_wmask_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int C_WORD_AW = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RBURST = 2'd1,
        WACK   = 2'd2
    } state_t;

    state_t               r_state;
    logic [C_WORD_AW-1:0] r_addr;      // word address of the last issued read

    logic                 w_req;
    logic                 w_burst;
    logic [C_WORD_AW-1:0] w_word_adr;
    logic [C_WORD_AW-1:0] w_next_addr;
    logic                 w_unused;

    assign w_req      = wb_cyc_i & wb_stb_i;
    // Only 010 continues a burst; reserved codes behave like classic / end.
    assign w_burst    = (wb_cti_i == 3'b010);
    assign w_word_adr = wb_adr_i[ADDR_WIDTH-1:2];
    // Byte lane bits are meaningless for a word-wide SRAM.
    assign w_unused   = &{1'b0, wb_adr_i[1:0]};

    assign ram_wmask_o = wb_sel_i;
    assign ram_wdata_o = wb_dat_i;

    // Next burst address: linear increment or wrap within a 4/8/16-word block.
    always_comb begin
        w_next_addr = r_addr + {{(C_WORD_AW-1){1'b0}}, 1'b1};
        case (wb_bte_i)
            2'b01:   w_next_addr = {r_addr[C_WORD_AW-1:2], r_addr[1:0] + 2'd1};
            2'b10:   w_next_addr = {r_addr[C_WORD_AW-1:3], r_addr[2:0] + 3'd1};
            2'b11:   w_next_addr = {r_addr[C_WORD_AW-1:4], r_addr[3:0] + 4'd1};
            default: w_next_addr = r_addr + {{(C_WORD_AW-1){1'b0}}, 1'b1};
        endcase
    end

    // Bus and SRAM strobes; combinational so a read issues in the request cycle.
    always_comb begin
        wb_ack_o   = 1'b0;
        wb_dat_o   = '0;
        ram_en_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = w_word_adr;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_req && !wb_we_i) begin
                        ram_en_o = 1'b1;
                    end
                end
                RBURST: begin
                    if (w_req) begin
                        wb_ack_o = 1'b1;
                        wb_dat_o = ram_rdata_i;
                        if (w_burst) begin
                            ram_en_o   = 1'b1;
                            ram_addr_o = w_next_addr;
                        end
                    end
                end
                WACK: begin
                    if (w_req) begin
                        wb_ack_o = 1'b1;
                        ram_en_o = 1'b1;
                        ram_we_o = 1'b1;
                    end
                end
                default: begin
                    wb_ack_o = 1'b0;
                end
            endcase
        end
    end

    // Cycle state and read address counter; any gap in req returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (wb_we_i) begin
                            r_state <= WACK;
                        end else begin
                            r_state <= RBURST;
                            r_addr  <= w_word_adr;
                        end
                    end
                end
                RBURST: begin
                    if (w_req && w_burst) begin
                        r_addr <= w_next_addr;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                WACK: begin
                    if (!(w_req && w_burst)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zet_ng_wb_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_zet_ng_wb_sram_bridge
// Description : Directed bench for the Wishbone-to-SRAM bridge with a
//               behavioural 1-cycle-latency SRAM attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zet_ng_wb_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [26:0] adr;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic [31:0] dat_o;
    logic        ram_en, ram_we;
    logic [24:0] ram_addr;
    logic [3:0]  ram_wmask;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:63];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    zet_ng_wb_sram_bridge #(.ADDR_WIDTH(27), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_adr_i    (adr),
        .wb_cyc_i    (cyc),
        .wb_stb_i    (stb),
        .wb_we_i     (we),
        .wb_sel_i    (sel),
        .wb_dat_i    (dat),
        .wb_cti_i    (cti),
        .wb_bte_i    (bte),
        .wb_ack_o    (ack),
        .wb_dat_o    (dat_o),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wmask_o (ram_wmask),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    // Behavioural synchronous SRAM: byte-masked write, registered read.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wmask[b]) mem[ram_addr[5:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end else begin
                ram_rdata <= mem[ram_addr[5:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one bus cycle's inputs at the falling edge, then let outputs settle.
    task automatic drive(input logic c, input logic s, input logic w, input logic [26:0] a,
                         input logic [3:0] sl, input logic [31:0] d,
                         input logic [2:0] ct, input logic [1:0] bt);
        @(negedge clk);
        cyc = c; stb = s; we = w; adr = a; sel = sl; dat = d; cti = ct; bte = bt;
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 1'b0, 27'h0, 4'h0, 32'h0, 3'b000, 2'b00);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[4]    = 32'hDEAD_BEEF;
        ram_rdata = 32'h0;
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat = '0; cti = '0; bte = '0;

        // Reset holds everything quiet even with a request presented
        drive(1'b1, 1'b1, 1'b0, 27'h10, 4'hF, 32'h0, 3'b000, 2'b00);
        chk("rst_ack", {31'b0, ack}, 32'h0);
        chk("rst_en",  {31'b0, ram_en}, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();

        // 1: classic read at 0x10
        drive(1'b1, 1'b1, 1'b0, 27'h10, 4'hF, 32'h0, 3'b000, 2'b00);
        chk("t1_c0_en",   {31'b0, ram_en}, 32'h1);
        chk("t1_c0_addr", {7'b0, ram_addr}, 32'h4);
        chk("t1_c0_ack",  {31'b0, ack}, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 27'h10, 4'hF, 32'h0, 3'b000, 2'b00);
        chk("t1_c1_ack",  {31'b0, ack}, 32'h1);
        chk("t1_c1_dat",  dat_o, 32'hDEAD_BEEF);
        chk("t1_c1_en",   {31'b0, ram_en}, 32'h0);
        idle_cycle();
        chk("t1_c2_ack",  {31'b0, ack}, 32'h0);

        // 2: linear burst of 4 from 0x0
        drive(1'b1, 1'b1, 1'b0, 27'h0, 4'hF, 32'h0, 3'b010, 2'b00);
        chk("t2_c0_addr", {7'b0, ram_addr}, 32'h0);
        chk("t2_c0_en",   {31'b0, ram_en}, 32'h1);
        drive(1'b1, 1'b1, 1'b0, 27'h4, 4'hF, 32'h0, 3'b010, 2'b00);
        chk("t2_c1_dat",  dat_o, 32'h1000_0000);
        chk("t2_c1_addr", {7'b0, ram_addr}, 32'h1);
        drive(1'b1, 1'b1, 1'b0, 27'h8, 4'hF, 32'h0, 3'b010, 2'b00);
        chk("t2_c2_dat",  dat_o, 32'h1000_0001);
        chk("t2_c2_addr", {7'b0, ram_addr}, 32'h2);
        drive(1'b1, 1'b1, 1'b0, 27'hC, 4'hF, 32'h0, 3'b010, 2'b00);
        chk("t2_c3_dat",  dat_o, 32'h1000_0002);
        chk("t2_c3_addr", {7'b0, ram_addr}, 32'h3);
        drive(1'b1, 1'b1, 1'b0, 27'hC, 4'hF, 32'h0, 3'b111, 2'b00);
        chk("t2_c4_ack",  {31'b0, ack}, 32'h1);
        chk("t2_c4_dat",  dat_o, 32'h1000_0003);
        chk("t2_c4_en",   {31'b0, ram_en}, 32'h0);
        idle_cycle();
        chk("t2_c5_ack",  {31'b0, ack}, 32'h0);
        chk("t2_c5_en",   {31'b0, ram_en}, 32'h0);

        // 3: wrap4 burst from 0x8 -> words 2,3,0,1
        drive(1'b1, 1'b1, 1'b0, 27'h8, 4'hF, 32'h0, 3'b010, 2'b01);
        chk("t3_c0_addr", {7'b0, ram_addr}, 32'h2);
        drive(1'b1, 1'b1, 1'b0, 27'hC, 4'hF, 32'h0, 3'b010, 2'b01);
        chk("t3_c1_dat",  dat_o, 32'h1000_0002);
        chk("t3_c1_addr", {7'b0, ram_addr}, 32'h3);
        drive(1'b1, 1'b1, 1'b0, 27'h0, 4'hF, 32'h0, 3'b010, 2'b01);
        chk("t3_c2_dat",  dat_o, 32'h1000_0003);
        chk("t3_c2_addr", {7'b0, ram_addr}, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 27'h4, 4'hF, 32'h0, 3'b010, 2'b01);
        chk("t3_c3_dat",  dat_o, 32'h1000_0000);
        chk("t3_c3_addr", {7'b0, ram_addr}, 32'h1);
        drive(1'b1, 1'b1, 1'b0, 27'h4, 4'hF, 32'h0, 3'b111, 2'b01);
        chk("t3_c4_dat",  dat_o, 32'h1000_0001);
        chk("t3_c4_en",   {31'b0, ram_en}, 32'h0);
        idle_cycle();

        // 4: write burst of 3 from 0x20, sel F,3,C
        drive(1'b1, 1'b1, 1'b1, 27'h20, 4'hF, 32'h1122_3344, 3'b010, 2'b00);
        chk("t4_c0_ack",  {31'b0, ack}, 32'h0);
        chk("t4_c0_en",   {31'b0, ram_en}, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 27'h20, 4'hF, 32'h1122_3344, 3'b010, 2'b00);
        chk("t4_c1_ack",  {31'b0, ack}, 32'h1);
        chk("t4_c1_we",   {31'b0, ram_we}, 32'h1);
        chk("t4_c1_addr", {7'b0, ram_addr}, 32'h8);
        chk("t4_c1_mask", {28'b0, ram_wmask}, 32'hF);
        drive(1'b1, 1'b1, 1'b1, 27'h24, 4'h3, 32'h5566_7788, 3'b010, 2'b00);
        chk("t4_c2_ack",  {31'b0, ack}, 32'h1);
        chk("t4_c2_addr", {7'b0, ram_addr}, 32'h9);
        chk("t4_c2_mask", {28'b0, ram_wmask}, 32'h3);
        drive(1'b1, 1'b1, 1'b1, 27'h28, 4'hC, 32'h99AA_BBCC, 3'b111, 2'b00);
        chk("t4_c3_ack",  {31'b0, ack}, 32'h1);
        chk("t4_c3_addr", {7'b0, ram_addr}, 32'hA);
        chk("t4_c3_mask", {28'b0, ram_wmask}, 32'hC);
        idle_cycle();
        chk("t4_c4_ack",  {31'b0, ack}, 32'h0);
        // Readback of words 8, 9, 10 via classic reads
        drive(1'b1, 1'b1, 1'b0, 27'h20, 4'hF, 32'h0, 3'b000, 2'b00);
        drive(1'b1, 1'b1, 1'b0, 27'h20, 4'hF, 32'h0, 3'b000, 2'b00);
        chk("t4_rb8",  dat_o, 32'h1122_3344);
        drive(1'b1, 1'b1, 1'b0, 27'h24, 4'hF, 32'h0, 3'b000, 2'b00);
        drive(1'b1, 1'b1, 1'b0, 27'h24, 4'hF, 32'h0, 3'b000, 2'b00);
        chk("t4_rb9",  dat_o, 32'h1000_7788);
        drive(1'b1, 1'b1, 1'b0, 27'h28, 4'hF, 32'h0, 3'b000, 2'b00);
        drive(1'b1, 1'b1, 1'b0, 27'h28, 4'hF, 32'h0, 3'b000, 2'b00);
        chk("t4_rb10", dat_o, 32'h99AA_000A);
        idle_cycle();

        // 5: read burst aborted by cyc drop after beat 2, then classic read
        drive(1'b1, 1'b1, 1'b0, 27'h30, 4'hF, 32'h0, 3'b010, 2'b00);
        drive(1'b1, 1'b1, 1'b0, 27'h34, 4'hF, 32'h0, 3'b010, 2'b00);
        chk("t5_b1_dat", dat_o, 32'h1000_000C);
        drive(1'b1, 1'b1, 1'b0, 27'h38, 4'hF, 32'h0, 3'b010, 2'b00);
        chk("t5_b2_dat", dat_o, 32'h1000_000D);
        idle_cycle();
        chk("t5_abort_ack", {31'b0, ack}, 32'h0);
        chk("t5_abort_en",  {31'b0, ram_en}, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 27'h40, 4'hF, 32'h0, 3'b000, 2'b00);
        chk("t5_new_en",   {31'b0, ram_en}, 32'h1);
        chk("t5_new_addr", {7'b0, ram_addr}, 32'h10);
        drive(1'b1, 1'b1, 1'b0, 27'h40, 4'hF, 32'h0, 3'b000, 2'b00);
        chk("t5_new_dat",  dat_o, 32'h1000_0010);
        idle_cycle();

        // 6a: reset during beat 2 of a write burst
        drive(1'b1, 1'b1, 1'b1, 27'h50, 4'hF, 32'hAAAA_5555, 3'b010, 2'b00);
        drive(1'b1, 1'b1, 1'b1, 27'h50, 4'hF, 32'hAAAA_5555, 3'b010, 2'b00);
        chk("t6_b1_ack", {31'b0, ack}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        adr = 27'h54; dat = 32'hBBBB_6666;
        #1;
        chk("t6_rst_ack", {31'b0, ack}, 32'h0);
        chk("t6_rst_en",  {31'b0, ram_en}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();
        // A read here would be a write if the bridge were still in WACK
        drive(1'b1, 1'b1, 1'b0, 27'h54, 4'hF, 32'h0, 3'b000, 2'b00);
        chk("t6_idle_en", {31'b0, ram_en}, 32'h1);
        chk("t6_idle_we", {31'b0, ram_we}, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 27'h54, 4'hF, 32'h0, 3'b000, 2'b00);
        chk("t6_rb21", dat_o, 32'h1000_0015);
        idle_cycle();

        // 6b: stb-low wait state mid read burst, master re-presents beat 2 address
        drive(1'b1, 1'b1, 1'b0, 27'h60, 4'hF, 32'h0, 3'b010, 2'b00);
        drive(1'b1, 1'b1, 1'b0, 27'h64, 4'hF, 32'h0, 3'b010, 2'b00);
        chk("t6w_b1_dat", dat_o, 32'h1000_0018);
        drive(1'b1, 1'b0, 1'b0, 27'h64, 4'hF, 32'h0, 3'b010, 2'b00);
        chk("t6w_wait_ack", {31'b0, ack}, 32'h0);
        chk("t6w_wait_en",  {31'b0, ram_en}, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 27'h64, 4'hF, 32'h0, 3'b010, 2'b00);
        chk("t6w_reissue_addr", {7'b0, ram_addr}, 32'h19);
        chk("t6w_reissue_ack",  {31'b0, ack}, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 27'h64, 4'hF, 32'h0, 3'b111, 2'b00);
        chk("t6w_b2_dat", dat_o, 32'h1000_0019);
        idle_cycle();

        // wrap8 from word 14 -> 14,15,8
        drive(1'b1, 1'b1, 1'b0, 27'h38, 4'hF, 32'h0, 3'b010, 2'b10);
        chk("w8_c0_addr", {7'b0, ram_addr}, 32'hE);
        drive(1'b1, 1'b1, 1'b0, 27'h3C, 4'hF, 32'h0, 3'b010, 2'b10);
        chk("w8_c1_addr", {7'b0, ram_addr}, 32'hF);
        drive(1'b1, 1'b1, 1'b0, 27'h20, 4'hF, 32'h0, 3'b010, 2'b10);
        chk("w8_c2_addr", {7'b0, ram_addr}, 32'h8);
        chk("w8_c2_dat",  dat_o, 32'h1000_000F);
        drive(1'b1, 1'b1, 1'b0, 27'h20, 4'hF, 32'h0, 3'b111, 2'b10);
        chk("w8_c3_dat",  dat_o, 32'h1122_3344);
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
